// File: rtl/fp51_loader_pkg.sv
// fp51_loader_pkg
// Shared definitions for the FP51 boot loader: FSM state encoding, frame
// sync/command bytes and the one-byte status codes returned per frame.
package fp51_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_ADDR_HI = 3'd2,
        S_ADDR_LO = 3'd3,
        S_LEN     = 3'd4,
        S_DATA    = 3'd5,
        S_CSUM    = 3'd6,
        S_RESP    = 3'd7
    } loader_state_t;

    localparam logic [7:0] LOADER_SYNC = 8'h5A;
    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_RUN     = 8'h02;

    localparam logic [7:0] ST_OK       = 8'hA5;
    localparam logic [7:0] ST_BAD_CMD  = 8'hE1;
    localparam logic [7:0] ST_BAD_CSUM = 8'hE2;
    localparam logic [7:0] ST_TIMEOUT  = 8'hE3;

endpackage

// File: rtl/fp51_loader_word_asm.sv
// fp51_loader_word_asm
// Packs an MSB-first byte stream into 32-bit instruction words and issues one
// registered write per completed word, stepping a wrapping word-address counter.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        discard any partially assembled word (lane counter to 0)
//   byte_valid   byte_data is a payload byte to absorb this cycle
//   byte_data    payload byte
//   addr_load    load the address counter from addr_value
//   addr_value   start word address
//   word_last    current byte (if valid) completes a word
//   we           one-cycle write strobe
//   wr_addr      word address of the write
//   data_out     assembled instruction word
module fp51_loader_word_asm #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    output logic              word_last,
    output logic              we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       data_out
);

    logic [1:0]        lane;
    logic [23:0]       shift;
    logic [ADDR_W-1:0] addr_cnt;
    logic              take;

    assign word_last = (lane == 2'd3);
    assign take      = byte_valid && !clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            we       <= 1'b0;
            wr_addr  <= '0;
            data_out <= '0;
            lane     <= 2'd0;
        end else begin
            we <= 1'b0;
            if (clear) begin
                lane <= 2'd0;
            end else if (byte_valid) begin
                if (word_last) begin
                    we       <= 1'b1;
                    data_out <= {shift, byte_data};
                    wr_addr  <= addr_cnt;
                    lane     <= 2'd0;
                end else begin
                    lane <= lane + 2'd1;
                end
            end
        end
    end

    // Datapath holding registers carry no reset; the lane counter above
    // decides when their contents are meaningful.
    always_ff @(posedge clk) begin
        if (addr_load) begin
            addr_cnt <= addr_value;
        end else if (take && word_last) begin
            addr_cnt <= addr_cnt + 1'b1;
        end
        if (take && !word_last) begin
            shift <= {shift[15:0], byte_data};
        end
    end

endmodule

// File: rtl/fp51_code_loader.sv
// fp51_code_loader
// UART-fed boot loader for the FP51 MCU. Parses WRITE/RUN frames, writes
// instruction words into instruction memory, holds the core in reset until a
// valid RUN frame, and returns a status byte per frame.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   resp_data         status byte (A5/E1/E2/E3)
//   resp_valid        held until resp_ready
//   resp_ready        transmit path accepts the status byte
//   inst_mem_we       one-cycle instruction-memory write strobe
//   inst_mem_wr_addr  word address
//   inst_mem_data_in  instruction word
//   cpu_hold          keeps the MCU in reset while high
//   busy              high whenever the FSM is not IDLE
module fp51_code_loader
    import fp51_loader_pkg::*;
#(
    parameter int PC_BITWIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             resp_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   inst_mem_we,
    output logic [PC_BITWIDTH-3:0] inst_mem_wr_addr,
    output logic [31:0]            inst_mem_data_in,
    output logic                   cpu_hold,
    output logic                   busy
);

    localparam int ADDR_W = PC_BITWIDTH - 2;
    localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    loader_state_t state;
    logic [7:0]    csum;
    logic [7:0]    csum_next;
    logic [7:0]    addr_hi;
    logic [8:0]    word_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic          run_flag;
    logic          in_frame;
    logic          timeout_hit;
    logic          word_last;
    logic          data_byte;

    assign csum_next   = csum + rx_data;
    assign in_frame    = (state != S_IDLE) && (state != S_RESP);
    assign timeout_hit = in_frame && !rx_valid && (gap_cnt == GAP_LAST);
    assign data_byte   = (state == S_DATA) && rx_valid;

    fp51_loader_word_asm #(
        .ADDR_W (ADDR_W)
    ) u_word_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == S_IDLE),
        .byte_valid (data_byte),
        .byte_data  (rx_data),
        .addr_load  ((state == S_ADDR_LO) && rx_valid),
        .addr_value (ADDR_W'({addr_hi, rx_data})),
        .word_last  (word_last),
        .we         (inst_mem_we),
        .wr_addr    (inst_mem_wr_addr),
        .data_out   (inst_mem_data_in)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 8'h00;
            cpu_hold   <= 1'b1;
            run_flag   <= 1'b0;
            csum       <= 8'h00;
            addr_hi    <= 8'h00;
            word_cnt   <= 9'd0;
            gap_cnt    <= '0;
        end else begin
            // Inter-byte gap only counts while a frame is open.
            if (in_frame && !rx_valid) gap_cnt <= gap_cnt + 1'b1;
            else                       gap_cnt <= '0;

            unique case (state)
                S_IDLE: begin
                    if (rx_valid && rx_data == LOADER_SYNC) begin
                        state    <= S_CMD;
                        busy     <= 1'b1;
                        csum     <= 8'h00;
                        run_flag <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (rx_valid) begin
                        csum <= csum_next;
                        if (rx_data == CMD_WRITE) begin
                            state <= S_ADDR_HI;
                        end else if (rx_data == CMD_RUN) begin
                            state    <= S_CSUM;
                            run_flag <= 1'b1;
                        end else begin
                            state      <= S_RESP;
                            resp_data  <= ST_BAD_CMD;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                S_ADDR_HI: begin
                    if (rx_valid) begin
                        csum    <= csum_next;
                        addr_hi <= rx_data;
                        state   <= S_ADDR_LO;
                    end
                end
                S_ADDR_LO: begin
                    if (rx_valid) begin
                        csum  <= csum_next;
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        csum     <= csum_next;
                        word_cnt <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        csum <= csum_next;
                        if (word_last) begin
                            word_cnt <= word_cnt - 9'd1;
                            if (word_cnt == 9'd1) state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        csum       <= csum_next;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        if (csum_next == 8'h00) begin
                            resp_data <= ST_OK;
                            if (run_flag) cpu_hold <= 1'b0;
                        end else begin
                            resp_data <= ST_BAD_CSUM;
                        end
                    end
                end
                S_RESP: begin
                    // Incoming bytes are ignored until the status is taken.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Timeout overrides whatever the frame states decided above.
            if (timeout_hit) begin
                state      <= S_RESP;
                resp_data  <= ST_TIMEOUT;
                resp_valid <= 1'b1;
            end
        end
    end

endmodule
